// File: rtl/apb_uart8_pkg.sv
// Purpose: shared register map, STATUS/CTRL bit positions and FSM encodings for apb_uart8.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package apb_uart8_pkg;

  // Register offsets (paddr[2:0])
  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DIV_LO = 3'd2;
  localparam logic [2:0] REG_DIV_HI = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;

  // STATUS bit indices
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_TX_BUSY  = 4;

  // CTRL bit indices
  localparam int CT_TX_EN      = 0;
  localparam int CT_RX_EN      = 1;
  localparam int CT_IRQ_RX_EN  = 2;
  localparam int CT_IRQ_TXE_EN = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Offsets 5..7 are not mapped.
  function automatic logic reg_invalid(input logic [2:0] a);
    return a > REG_CTRL;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO holding bytes queued for transmission.
// Latency: a push is visible on rdata_o/empty_o the cycle after it is accepted.
// Backpressure: push ignored while full, pop ignored while empty; push vs pop on full -> push dropped.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write side;
//        pop_i/rdata_o read side; full_o/empty_o occupancy flags.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/apb_uart8.sv
// Purpose: APB-attached 8N1 UART with TX FIFO and single-byte RX holding register (RX path under UART_RX_EN).
// Latency: zero-wait-state APB; a queued byte starts its start bit two cycles after the DATA write.
// Backpressure: DATA write to a full TX FIFO drops the byte and returns pslverr.
// Ports: clk_i/rst_ni clock and async active-low reset; psel/penable/pwrite/paddr/pwdata/prdata/
//        pready/pslverr APB slave; uart_tx serial out; uart_rx serial in; irq_o level interrupt.
// Build option: define UART_RX_EN to include the receiver.
module apb_uart8 import apb_uart8_pkg::*; #(
  parameter int          AWID      = 32,
  parameter int          APB_DWID  = 8,
  parameter int          TXF_DEPTH = 8,
  parameter logic [15:0] DIV_RST   = 16'd433
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [AWID-1:0]     paddr,
  input  logic [APB_DWID-1:0] pwdata,
  output logic [APB_DWID-1:0] prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                uart_tx,
  input  logic                uart_rx,
  output logic                irq_o
);

  logic [2:0]  reg_addr;
  logic [7:0]  wdat, rdata;
  logic        access, err, wr_ok, rd_ok, div_wr;
  logic        fifo_full, fifo_empty, tx_pop, tx_busy;
  logic [7:0]  fifo_rdata;
  logic [15:0] div_q, div_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        irq_q, irq_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_q, tx_d;
  logic        rx_valid_w, rx_ovr_w;
  logic [7:0]  rx_hold_w;
  logic        unused_paddr;

  assign reg_addr     = paddr[2:0];
  assign unused_paddr = ^paddr[AWID-1:3];
  assign wdat         = pwdata[7:0];
  assign access       = psel & penable;
  assign err          = access & (reg_invalid(reg_addr) |
                                  (pwrite & (reg_addr == REG_DATA) & fifo_full));
  assign wr_ok        = access & pwrite & ~err;
  assign rd_ok        = access & ~pwrite & ~err;
  assign div_wr       = wr_ok & ((reg_addr == REG_DIV_LO) | (reg_addr == REG_DIV_HI));
  assign pready       = access;
  assign pslverr      = err;
  assign tx_busy      = (tx_state_q != TX_IDLE);
  assign uart_tx      = tx_q;
  assign irq_o        = irq_q;

  uart_fifo #(.DEPTH(TXF_DEPTH), .WIDTH(8)) u_txf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_ok & (reg_addr == REG_DATA)),
    .wdata_i (wdat),
    .pop_i   (tx_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rdata = 8'h00;
    case (reg_addr)
      REG_DATA:   rdata = rx_hold_w;
      REG_STATUS: rdata = {3'b000, tx_busy, rx_ovr_w, rx_valid_w, fifo_empty, fifo_full};
      REG_DIV_LO: rdata = div_q[7:0];
      REG_DIV_HI: rdata = div_q[15:8];
      REG_CTRL:   rdata = {4'b0000, ctrl_q};
      default:    rdata = 8'h00;
    endcase
    prdata = rd_ok ? rdata : '0;
  end

  always_comb begin
    div_d  = div_q;
    ctrl_d = ctrl_q;
    if (wr_ok && reg_addr == REG_DIV_LO) div_d[7:0]  = wdat;
    if (wr_ok && reg_addr == REG_DIV_HI) div_d[15:8] = wdat;
    if (wr_ok && reg_addr == REG_CTRL)   ctrl_d      = wdat[3:0];
    irq_d = (ctrl_q[CT_IRQ_RX_EN] & rx_valid_w) |
            (ctrl_q[CT_IRQ_TXE_EN] & fifo_empty & ~tx_busy);
  end

  // TX: bit time is div+1 cycles, counted down to zero in each state.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (ctrl_q[CT_TX_EN] && !fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = fifo_rdata;
          tx_d       = 1'b0;
          tx_cnt_d   = div_q;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = TX_DATA;
          tx_d       = tx_sh_q[0];
          tx_bit_d   = 3'd0;
          tx_cnt_d   = div_q;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_q;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_d     = tx_sh_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          // Back-to-back frames skip IDLE; a cleared tx_en halts here.
          if (ctrl_q[CT_TX_EN] && !fifo_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = fifo_rdata;
            tx_d       = 1'b0;
            tx_cnt_d   = div_q;
            tx_state_d = TX_START;
          end else tx_state_d = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (div_wr) tx_cnt_d = div_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q      <= DIV_RST;
      ctrl_q     <= 4'b0011;
      irq_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      div_q      <= div_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
    end
  end

`ifdef UART_RX_EN
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_done, rd_data_acc;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_sh_q, rx_sh_d, rx_hold_q, rx_hold_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;

  assign rx_valid_w  = rx_valid_q;
  assign rx_ovr_w    = rx_ovr_q;
  assign rx_hold_w   = rx_hold_q;
  assign rd_data_acc = rd_ok & (reg_addr == REG_DATA);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (ctrl_q[CT_RX_EN] && rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = div_q >> 1;  // land roughly mid start bit
        end
      end
      RX_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) rx_state_d = RX_IDLE;  // glitch, not a start bit
          else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = div_q;
            rx_bit_d   = 3'd0;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = div_q;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = RX_IDLE;
          rx_done    = rx_s2_q;  // bad stop bit: byte silently dropped
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (div_wr) rx_cnt_d = div_d;

    rx_hold_d  = rx_hold_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    if (wr_ok && reg_addr == REG_STATUS && wdat[ST_RX_OVR]) rx_ovr_d = 1'b0;
    // A read racing completion consumed the old byte, so it is not an overrun.
    if (rx_done) begin
      rx_hold_d  = rx_sh_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd_data_acc) rx_ovr_d = 1'b1;
    end else if (rd_data_acc) rx_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_hold_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
      rx_hold_q  <= rx_hold_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end
`else
  logic unused_uart_rx;
  assign unused_uart_rx = uart_rx;
  assign rx_valid_w     = 1'b0;
  assign rx_ovr_w       = 1'b0;
  assign rx_hold_w      = 8'h00;
`endif

endmodule

// File: doc/apb_uart8.md
APB_UART8 -- requirements
Module: apb_uart8

Interface
REQ-001 SHALL have parameter AWID, default 32, APB address width.
REQ-002 SHALL have parameter APB_DWID, default 8, APB data width (the block supports 8 only).
REQ-003 SHALL have parameter TXF_DEPTH, default 8, TX FIFO entries (power of two, 2..64).
REQ-004 SHALL have parameter DIV_RST, default 16'd433, baud divisor reset value.
REQ-005 SHALL have ports clk_i (in, 1, sole clock) and rst_ni (in, 1). The block uses one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports psel, penable, pwrite (in, 1 each; APB control), paddr (in, AWID; only [2:0] is decoded) and pwdata (in, 8).
REQ-007 SHALL have ports prdata (out, 8), pready (out, 1) and pslverr (out, 1).
REQ-008 SHALL have ports uart_tx (out, 1, serial out, idle high), uart_rx (in, 1, asynchronous serial in) and irq_o (out, 1, level interrupt).

Function
REQ-009 SHALL treat an access as occurring in the cycle where psel&penable; pready is 1 combinationally in that cycle (zero wait states).
REQ-010 SHALL decode the following registers:
  - paddr[2:0]=0: DATA. Write pushes TX FIFO; read returns the RX holding byte and clears rx_valid.
  - 1: STATUS (RO, except W1C on bit3): {3'b0, tx_busy, rx_ovr, rx_valid, tx_empty, tx_full}.
  - 2: DIV_LO.
  - 3: DIV_HI.
  - 4: CTRL[3:0] = {irq_txe_en, irq_rx_en, rx_en, tx_en}.
REQ-011 SHALL assert pslverr, with no side effect, for paddr[2:0] in 5..7, and for a DATA write while the TX FIFO is full (byte dropped).
REQ-012 SHALL drive prdata=0 outside read-access cycles and on error.
REQ-013 SHALL generate bit time as DIV+1 clk_i cycles from a 16-bit down-counter. The counter reloads on DIV write and on every bit boundary.
REQ-014 SHALL implement the TX FSM IDLE->START->DATA->STOP->IDLE:
  - Leave IDLE only when tx_en=1 and the FIFO is non-empty; pop in that cycle.
  - Send LSB first, 8N1.
  - STOP returns directly to START if the FIFO is non-empty (back-to-back).
REQ-015 SHALL drive tx_busy=1 whenever the TX FSM is not in IDLE. Clearing tx_en mid-frame finishes the current frame, then halts.
REQ-016 SHALL implement the RX FSM IDLE->START->DATA->STOP:
  - Input is uart_rx through a 2-flop synchroniser.
  - A falling edge in IDLE with rx_en=1 starts a frame.
  - Sample START at (DIV+1)/2 cycles; if it is high there, return to IDLE (glitch).
  - Sample each subsequent bit at bit-centre.
REQ-017 SHALL load the RX holding register and set rx_valid at STOP sample when stop=1. When stop=0 it SHALL discard the byte silently.
REQ-018 SHALL set rx_ovr and overwrite the holding byte when a new byte completes while rx_valid=1. rx_ovr clears on a STATUS write with pwdata[3]=1.
REQ-019 SHALL resolve a DATA read in the same cycle as RX completion by returning the old byte, then leaving rx_valid=1 with the new byte and no overrun.
REQ-020 SHALL resolve a push and a pop in the same cycle on a full FIFO by rejecting the push (pslverr=1).
REQ-021 SHALL drive irq_o = (irq_rx_en&rx_valid) | (irq_txe_en&tx_empty&!tx_busy), registered.

Reset
REQ-022 SHALL on rst_ni low, asynchronously apply the following reset values:
  - uart_tx=1, irq_o=0.
  - FIFO empty; both FSMs in IDLE.
  - rx_valid=0, rx_ovr=0.
  - DIV=DIV_RST, CTRL=4'b0011.
  - Synchroniser flops=1.
REQ-023 SHALL abandon an in-flight frame on reset mid-frame; uart_tx is high within 0 cycles of assertion.

Configuration
REQ-024 SHALL compile the RX path (synchroniser, RX FSM, holding register, rx_valid/rx_ovr) only when UART_RX_EN is defined.
REQ-025 SHALL, without UART_RX_EN:
  - read rx_valid, rx_ovr and DATA as 0;
  - not error on DATA reads;
  - leave uart_rx unused;
  - treat irq_rx_en as writable but without effect.

Structure
REQ-026 SHALL place the register offsets, STATUS/CTRL bit indices and the TX/RX FSM state encodings in package apb_uart8_pkg.
REQ-027 SHALL implement the TX FIFO as sub-module uart_fifo (sync, depth TXF_DEPTH, full/empty flags, pointer width clog2+1 with wrap bit).

Verification
REQ-028 SHALL cover: reset -> uart_tx=1; STATUS reads 0x02; DIV reads 0x01B1; CTRL reads 0x03.
REQ-029 SHALL cover: DIV=3, write DATA 0xA5 -> uart_tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; tx_busy=0 after.
REQ-030 SHALL cover: nine DATA writes with tx_en=0 -> first eight pready=1/pslverr=0, ninth pslverr=1; STATUS bit0=1.
REQ-031 SHALL cover: DIV=7, drive frame 0x3C on uart_rx -> rx_valid=1, irq_o=1 with irq_rx_en; DATA read returns 0x3C; rx_valid=0.
REQ-032 SHALL cover: two RX frames 0x11, 0x22 without a read -> DATA=0x22, STATUS bit3=1; write 0x08 to STATUS clears it.
REQ-033 SHALL cover: read paddr=6 -> pslverr=1, prdata=0; reset asserted mid-TX frame -> uart_tx=1 immediately and FIFO empty.
